// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Single-issue sequencer around a 16-bit combinational ALU. An instruction is
// accepted in IDLE, its operands are registered onto the ALU inputs, the ALU
// settles during EXEC, and the result, flags, PC and return stack update on
// the EXEC edge. The result is held in DONE until the consumer takes it.
// Control opcodes (0x12-0x18) ignore the ALU and resolve branches against the
// flag register left by the previous instruction.

module alu_issue_ctrl #(
  parameter int                DATA_W      = 16,
  parameter int                STACK_DEPTH = 4,
  parameter logic [DATA_W-1:0] PC_RESET    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [5:0]        instr_op,
  input  logic [DATA_W-1:0] instr_a,
  input  logic [DATA_W-1:0] instr_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_flags,
  output logic [DATA_W-1:0] pc,
  output logic              branch_taken,
  output logic              illegal_op,
  output logic              stack_err
);

  // Stack pointer counts occupied entries, 0..STACK_DEPTH inclusive.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]   SP_EMPTY = SP_W'(0);
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
  localparam logic [DATA_W-1:0] PC_ONE   = DATA_W'(1);

  localparam logic [5:0] OP_LAST_ALU = 6'h11;
  localparam logic [5:0] OP_BRZ      = 6'h12;
  localparam logic [5:0] OP_BRN      = 6'h13;
  localparam logic [5:0] OP_BRC      = 6'h14;
  localparam logic [5:0] OP_BRO      = 6'h15;
  localparam logic [5:0] OP_BRA      = 6'h16;
  localparam logic [5:0] OP_JMP      = 6'h17;
  localparam logic [5:0] OP_RET      = 6'h18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Conditional branch test against the stored {Z,N,C,O} flags.
  function automatic logic branch_cond(input logic [5:0] op, input logic [3:0] flg);
    logic hit;
    case (op)
      OP_BRZ:  hit = flg[3];
      OP_BRN:  hit = flg[2];
      OP_BRC:  hit = flg[1];
      OP_BRO:  hit = flg[0];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_t              state_r, state_nxt_s;
  logic                ready_s, valid_s;

  logic [DATA_W-1:0]   alu_a_r, alu_b_r;
  logic [5:0]          alu_op_r;
  logic [DATA_W-1:0]   res_data_r, pc_r;
  logic [3:0]          flags_r;
  logic                taken_r, illegal_r, stack_err_r;

  logic [SP_W-1:0]     sp_r;
  logic [DATA_W-1:0]   stack_r [SLOTS];
  logic [IDX_W-1:0]    push_idx_s, pop_idx_s;

  logic [DATA_W-1:0]   pc_inc_s, nxt_pc_s, nxt_data_s;
  logic [3:0]          nxt_flags_s;
  logic                nxt_taken_s, nxt_ill_s;
  logic                push_s, pop_s, err_set_s;

  assign pc_inc_s   = pc_r + PC_ONE;
  assign push_idx_s = IDX_W'(sp_r);
  assign pop_idx_s  = IDX_W'(sp_r - SP_ONE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: one cycle of EXEC, DONE waits for the consumer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (res_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake strobes decoded from the state register.
  always_comb begin
    ready_s = 1'b0;
    valid_s = 1'b0;
    case (state_r)
      ST_IDLE: ready_s = 1'b1;
      ST_DONE: valid_s = 1'b1;
      default: begin
        ready_s = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  // Operand capture: ALU inputs are registered when an instruction is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r  <= {DATA_W{1'b0}};
      alu_b_r  <= {DATA_W{1'b0}};
      alu_op_r <= 6'h00;
    end else if ((state_r == ST_IDLE) && instr_valid) begin
      alu_a_r  <= instr_a;
      alu_b_r  <= instr_b;
      alu_op_r <= instr_op;
    end
  end

  // Execute decode: new PC, result, flags and stack action for the latched op.
  always_comb begin
    nxt_pc_s    = pc_inc_s;
    nxt_data_s  = {DATA_W{1'b0}};
    nxt_flags_s = flags_r;
    nxt_taken_s = 1'b0;
    nxt_ill_s   = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    err_set_s   = 1'b0;
    if (alu_op_r <= OP_LAST_ALU) begin
      nxt_data_s  = alu_result;
      nxt_flags_s = {alu_z, alu_n, alu_c, alu_o};
    end else begin
      case (alu_op_r)
        OP_BRZ, OP_BRN, OP_BRC, OP_BRO: begin
          if (branch_cond(alu_op_r, flags_r)) begin
            nxt_pc_s    = alu_b_r;
            nxt_taken_s = 1'b1;
          end else begin
            nxt_pc_s    = pc_inc_s;
          end
        end
        OP_BRA: begin
          nxt_pc_s    = alu_b_r;
          nxt_taken_s = 1'b1;
        end
        OP_JMP: begin
          if (sp_r == SP_FULL) begin
            err_set_s   = 1'b1;
          end else begin
            push_s      = 1'b1;
            nxt_pc_s    = alu_b_r;
            nxt_taken_s = 1'b1;
          end
        end
        OP_RET: begin
          if (sp_r == SP_EMPTY) begin
            err_set_s   = 1'b1;
          end else begin
            pop_s       = 1'b1;
            nxt_pc_s    = stack_r[pop_idx_s];
            nxt_taken_s = 1'b1;
          end
        end
        default: nxt_ill_s = 1'b1;
      endcase
      // Control ops report the new PC; illegal ops report zero.
      if (nxt_ill_s) begin
        nxt_data_s = {DATA_W{1'b0}};
      end else begin
        nxt_data_s = nxt_pc_s;
      end
    end
  end

  // Result, flag and PC registers load on the EXEC edge and hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_r  <= {DATA_W{1'b0}};
      flags_r     <= 4'h0;
      pc_r        <= PC_RESET;
      taken_r     <= 1'b0;
      illegal_r   <= 1'b0;
      stack_err_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      res_data_r  <= nxt_data_s;
      flags_r     <= nxt_flags_s;
      pc_r        <= nxt_pc_s;
      taken_r     <= nxt_taken_s;
      illegal_r   <= nxt_ill_s;
      stack_err_r <= stack_err_r | err_set_s;
    end
  end

  // Return-address stack: push stores pc+1 (wrapping), pop just drops the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= SP_EMPTY;
      for (int i = 0; i < SLOTS; i++) begin
        stack_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == ST_EXEC) && push_s) begin
      stack_r[push_idx_s] <= pc_inc_s;
      sp_r                <= sp_r + SP_ONE;
    end else if ((state_r == ST_EXEC) && pop_s) begin
      sp_r                <= sp_r - SP_ONE;
    end
  end

  assign instr_ready  = ready_s;
  assign res_valid    = valid_s;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_op       = alu_op_r;
  assign res_data     = res_data_r;
  assign res_flags    = flags_r;
  assign pc           = pc_r;
  assign branch_taken = taken_r;
  assign illegal_op   = illegal_r;
  assign stack_err    = stack_err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed instructions, a small behavioural ALU on
// the ALU side, and a scoreboard queue drained by an independent monitor.

module tb_alu_issue_ctrl;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_MUL = 6'h02;
  localparam logic [5:0] OP_CMP = 6'h0C;
  localparam logic [5:0] OP_BRZ = 6'h12;
  localparam logic [5:0] OP_BRN = 6'h13;
  localparam logic [5:0] OP_BRA = 6'h16;
  localparam logic [5:0] OP_JMP = 6'h17;
  localparam logic [5:0] OP_RET = 6'h18;
  localparam logic [5:0] OP_ILL = 6'h2A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ready;
  logic [5:0]  instr_op;
  logic [15:0] instr_a, instr_b;
  logic [15:0] alu_a, alu_b;
  logic [5:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_z, alu_n, alu_c, alu_o;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_flags;
  logic [15:0] pc;
  logic        branch_taken, illegal_op, stack_err;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  flags;
    logic [15:0] pc;
    logic        taken;
    logic        ill;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(16), .STACK_DEPTH(4), .PC_RESET(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_a(instr_a), .instr_b(instr_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_o(alu_o),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .pc(pc),
    .branch_taken(branch_taken), .illegal_op(illegal_op), .stack_err(stack_err)
  );

  // Behavioural ALU: ADD/SUB/CMP with carry(borrow)/overflow, MUL low half, else XOR.
  logic [16:0] wide_s;
  always_comb begin
    wide_s = 17'h00000;
    alu_o  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        wide_s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_o  = (alu_a[15] == alu_b[15]) && (wide_s[15] != alu_a[15]);
      end
      OP_SUB, OP_CMP: begin
        wide_s = {1'b0, alu_a} - {1'b0, alu_b};
        alu_o  = (alu_a[15] != alu_b[15]) && (wide_s[15] != alu_a[15]);
      end
      OP_MUL:  wide_s = {1'b0, alu_a * alu_b};
      default: wide_s = {1'b0, alu_a ^ alu_b};
    endcase
    alu_result = wide_s[15:0];
    alu_z      = (wide_s[15:0] == 16'h0000);
    alu_n      = wide_s[15];
    alu_c      = wide_s[16];
  end

  function automatic exp_t mk(input logic [15:0] data, input logic [3:0] flags,
                              input logic [15:0] p, input logic taken,
                              input logic ill, input logic err);
    exp_t e;
    e.data = data; e.flags = flags; e.pc = p; e.taken = taken; e.ill = ill; e.err = err;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res_data=%h pc=%h, expected no result", res_data, pc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("res_data", res_data, mon_e.data);
        chk("res_flags", 16'(res_flags), 16'(mon_e.flags));
        chk("pc", pc, mon_e.pc);
        chk("branch_taken", 16'(branch_taken), 16'(mon_e.taken));
        chk("illegal_op", 16'(illegal_op), 16'(mon_e.ill));
        chk("stack_err", 16'(stack_err), 16'(mon_e.err));
      end
    end
  end

  // Offer one instruction, push its expectation, check the two-edge latency.
  task automatic offer(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                       input exp_t e);
    int n;
    sb_q.push_back(e);
    instr_op = op; instr_a = a; instr_b = b; instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got instr_ready=%b expected 1 within 20 cycles", instr_ready);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec_no_valid", 16'(res_valid), 16'h0000);
    @(negedge clk);
    chk("lat_done_valid", 16'(res_valid), 16'h0001);
  endtask

  // Wait until the monitor consumed every expectation, then step past the handshake edge.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                       input exp_t e);
    offer(op, a, b, e);
    drain();
  endtask

  task automatic chk_zeroed(input string tag);
    chk({tag, "_alu_a"}, alu_a, 16'h0000);
    chk({tag, "_alu_b"}, alu_b, 16'h0000);
    chk({tag, "_alu_op"}, 16'(alu_op), 16'h0000);
    chk({tag, "_res_valid"}, 16'(res_valid), 16'h0000);
    chk({tag, "_res_data"}, res_data, 16'h0000);
    chk({tag, "_res_flags"}, 16'(res_flags), 16'h0000);
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_taken"}, 16'(branch_taken), 16'h0000);
    chk({tag, "_illegal"}, 16'(illegal_op), 16'h0000);
    chk({tag, "_stack_err"}, 16'(stack_err), 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; res_ready = 1'b1;
    instr_op = 6'h00; instr_a = 16'h0000; instr_b = 16'h0000;
    repeat (3) @(posedge clk);
    #1 chk_zeroed("reset");
    chk("reset_instr_ready", 16'(instr_ready), 16'h0001);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ADD 12+8
    issue(OP_ADD, 16'd12, 16'd8, mk(16'd20, 4'h0, 16'h0001, 1'b0, 1'b0, 1'b0));

    // 2: CMP 15,20 sets N (and borrow C); BRN taken; BRZ not taken
    issue(OP_CMP, 16'd15, 16'd20, mk(16'hFFFB, 4'h6, 16'h0002, 1'b0, 1'b0, 1'b0));
    issue(OP_BRN, 16'h0000, 16'h0040, mk(16'h0040, 4'h6, 16'h0040, 1'b1, 1'b0, 1'b0));
    issue(OP_BRZ, 16'h0000, 16'h0080, mk(16'h0041, 4'h6, 16'h0041, 1'b0, 1'b0, 1'b0));

    // 3: back to pc=0, five JMPs into a 4-deep stack, then five RETs
    issue(OP_BRA, 16'h0000, 16'h0000, mk(16'h0000, 4'h6, 16'h0000, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      issue(OP_JMP, 16'h0000, 16'h0100, mk(16'h0100, 4'h6, 16'h0100, 1'b1, 1'b0, 1'b0));
    end
    issue(OP_JMP, 16'h0000, 16'h0100, mk(16'h0101, 4'h6, 16'h0101, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      issue(OP_RET, 16'h0000, 16'h0000, mk(16'h0101, 4'h6, 16'h0101, 1'b1, 1'b0, 1'b1));
    end
    issue(OP_RET, 16'h0000, 16'h0000, mk(16'h0001, 4'h6, 16'h0001, 1'b1, 1'b0, 1'b1));
    issue(OP_RET, 16'h0000, 16'h0000, mk(16'h0002, 4'h6, 16'h0002, 1'b0, 1'b0, 1'b1));

    // 4: consumer stalls for 5 cycles; a new offer during DONE must be ignored
    res_ready = 1'b0;
    offer(OP_ADD, 16'd1, 16'd2, mk(16'd3, 4'h0, 16'h0003, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      instr_valid = 1'b1; instr_op = OP_SUB; instr_a = 16'd9; instr_b = 16'd9;
      @(negedge clk);
      chk("stall_res_valid", 16'(res_valid), 16'h0001);
      chk("stall_instr_ready", 16'(instr_ready), 16'h0000);
      chk("stall_res_data", res_data, 16'd3);
      chk("stall_pc", pc, 16'h0003);
      chk("stall_alu_a", alu_a, 16'd1);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    drain();
    chk("release_idle", 16'(instr_ready), 16'h0001);

    // 6: flags survive an illegal opcode; pc wraps from 0xFFFF
    issue(OP_CMP, 16'd15, 16'd20, mk(16'hFFFB, 4'h6, 16'h0004, 1'b0, 1'b0, 1'b1));
    issue(OP_BRA, 16'h0000, 16'hFFFF, mk(16'hFFFF, 4'h6, 16'hFFFF, 1'b1, 1'b0, 1'b1));
    issue(OP_ILL, 16'd5, 16'd6, mk(16'h0000, 4'h6, 16'h0000, 1'b0, 1'b1, 1'b1));

    // 5: reset asserted while a MUL is in EXEC
    issue(OP_ADD, 16'd2, 16'd3, mk(16'd5, 4'h0, 16'h0001, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    instr_valid = 1'b1; instr_op = OP_MUL; instr_a = 16'd7; instr_b = 16'd6;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zeroed("midexec_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_no_valid", 16'(res_valid), 16'h0000);
    end
    @(posedge clk);
    #1;

    // Fresh state after reset: ADD from pc 0, then RET on the emptied stack
    issue(OP_ADD, 16'd12, 16'd8, mk(16'd20, 4'h0, 16'h0001, 1'b0, 1'b0, 1'b0));
    issue(OP_RET, 16'h0000, 16'h0000, mk(16'h0002, 4'h0, 16'h0002, 1'b0, 1'b0, 1'b1));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
